// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level flags, show-ahead read
// data and one-cycle overflow/underflow pulses for flow control.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  winc,
  output logic                  wfull,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  wovf,
  output logic                  rudf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage is deliberately left out of reset; pointers alone define validity.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0]   wptr_reg, wptr_next;
  logic [ADDR_WIDTH:0]   rptr_reg, rptr_next;
  logic [ADDR_WIDTH:0]   level_reg, level_next;
  logic                  rempty_reg, rempty_next;
  logic                  wfull_reg, wfull_next;
  logic                  wovf_reg, rudf_reg;
  logic                  write_en, read_en;
  logic [DATA_WIDTH-1:0] head_word;

  // Acceptance decisions use the registered flags only, so a simultaneous
  // read never frees space for a write at full, nor a write feed a read at empty.
  always_comb begin
    write_en = winc && !wfull_reg && !rst;
    read_en  = rinc && !rempty_reg && !rst;
  end

  // Next pointer values and the exact flags derived from them.
  always_comb begin
    wptr_next   = wptr_reg + {{ADDR_WIDTH{1'b0}}, write_en};
    rptr_next   = rptr_reg + {{ADDR_WIDTH{1'b0}}, read_en};
    level_next  = wptr_next - rptr_next;
    rempty_next = (wptr_next == rptr_next);
    wfull_next  = (wptr_next[ADDR_WIDTH-1:0] == rptr_next[ADDR_WIDTH-1:0]) &&
                  (wptr_next[ADDR_WIDTH] != rptr_next[ADDR_WIDTH]);
  end

  // Pointer, flag and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg   <= '0;
      rptr_reg   <= '0;
      level_reg  <= '0;
      rempty_reg <= 1'b1;
      wfull_reg  <= 1'b0;
      wovf_reg   <= 1'b0;
      rudf_reg   <= 1'b0;
    end else begin
      wptr_reg   <= wptr_next;
      rptr_reg   <= rptr_next;
      level_reg  <= level_next;
      rempty_reg <= rempty_next;
      wfull_reg  <= wfull_next;
      wovf_reg   <= winc && wfull_reg;
      rudf_reg   <= rinc && rempty_reg;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wptr_reg[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

  // Show-ahead head word; stale storage is masked to zero while empty.
  always_comb begin
    head_word = mem[rptr_reg[ADDR_WIDTH-1:0]];
  end

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rdata_mask
    assign rdata[gi] = head_word[gi] & ~rempty_reg;
  end

  assign wfull  = wfull_reg;
  assign rempty = rempty_reg;
  assign level  = level_reg;
  assign wovf   = wovf_reg;
  assign rudf   = rudf_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based reference model predicts
// flags and read data; a monitor checks every consumed word.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wdata;
  logic          winc;
  logic          wfull;
  logic          rinc;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic [AW:0]   level;
  logic          wovf;
  logic          rudf;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .wdata  (wdata),
    .winc   (winc),
    .wfull  (wfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty),
    .level  (level),
    .wovf   (wovf),
    .rudf   (rudf)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference contents (oldest first) and words expected to be consumed.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  bit            exp_wovf = 1'b0;
  bit            exp_rudf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Compare DUT status outputs against the model's current state.
  task automatic check_state(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".level"},  32'(level),  32'(sz));
    chk({tag, ".rempty"}, 32'(rempty), 32'(sz == 0));
    chk({tag, ".wfull"},  32'(wfull),  32'(sz == DEPTH));
    chk({tag, ".wovf"},   32'(wovf),   32'(exp_wovf));
    chk({tag, ".rudf"},   32'(rudf),   32'(exp_rudf));
    if (sz == 0) chk({tag, ".rdata_empty"}, 32'(rdata), 32'h0);
    else         chk({tag, ".rdata_head"},  32'(rdata), 32'(model_q[0]));
  endtask

  // One clock cycle: check current state, drive a request, predict its effect.
  task automatic step(input string tag, input bit w, input logic [DW-1:0] d, input bit r);
    bit full, empty;
    check_state(tag);
    winc  = w;
    wdata = d;
    rinc  = r;
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    exp_wovf = w && full;
    exp_rudf = r && empty;
    if (r && !empty) exp_q.push_back(model_q.pop_front());
    if (w && !full)  model_q.push_back(d);
    $display("op %-8s w=%0d d=0x%02h r=%0d level_before=%0d", tag, w, d, r, level);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst   = 1'b1;
    winc  = 1'b1;
    wdata = 8'h33;
    rinc  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst  = 1'b0;
    winc = 1'b0;
    model_q.delete();
    exp_wovf = 1'b0;
    exp_rudf = 1'b0;
    $display("reset held %0d cycles", cycles);
  endtask

  // Monitor: every accepted read consumes the head word shown on rdata.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rinc && !rempty) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL mon.unexpected_read: got 0x%02h expected no read", rdata);
        end else begin
          e = exp_q.pop_front();
          chk("mon.rdata", 32'(rdata), 32'(e));
          $display("read 0x%02h expected 0x%02h", rdata, e);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] seq4 [4];
    int            cnt;
    seq4[0] = 8'h01; seq4[1] = 8'h02; seq4[2] = 8'h0A; seq4[3] = 8'h0B;
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;

    // Reset with winc held high.
    do_reset(2);

    // Four writes, then four reads.
    for (int i = 0; i < 4; i++) step("wr4", 1'b1, seq4[i], 1'b0);
    for (int i = 0; i < 4; i++) step("rd4", 1'b0, 8'h00, 1'b1);

    // Fill to full, overflow attempt, drain.
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0);
    step("ovf", 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1);

    // Underflow, then write+read on empty.
    step("udf", 1'b0, 8'h00, 1'b1);
    step("wr_rd_e", 1'b1, 8'h77, 1'b1);
    step("rd1", 1'b0, 8'h00, 1'b1);

    // Stream: simultaneous ops at level 8 and at full, with wrap-around.
    cnt = 8'h40;
    for (int i = 0; i < 8; i++) begin step("to8", 1'b1, 8'(cnt), 1'b0); cnt++; end
    for (int i = 0; i < 6; i++) begin step("rw@8", 1'b1, 8'(cnt), 1'b1); cnt++; end
    for (int i = 0; i < 8; i++) begin step("to16", 1'b1, 8'(cnt), 1'b0); cnt++; end
    for (int i = 0; i < 4; i++) begin step("rw@full", 1'b1, 8'(cnt), 1'b1); cnt++; end
    for (int i = 0; i < 200; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    while (model_q.size() > 0) step("flush", 1'b0, 8'h00, 1'b1);

    // Reset mid-operation discards contents.
    for (int i = 0; i < 10; i++) step("to10", 1'b1, 8'(8'hA0 + i), 1'b0);
    check_state("pre_rst");
    do_reset(1);
    step("wr5a", 1'b1, 8'h5A, 1'b0);
    step("rd5a", 1'b0, 8'h00, 1'b1);
    step("idle", 1'b0, 8'h00, 1'b0);
    check_state("final");

    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
